// File: rtl/pcap_stream_arbiter_2to1.sv
// Packet-atomic round-robin merge of two 64-bit Avalon-ST streams onto one registered source,
// with a programmable idle gap between packets, per-input packet counters and a sticky framing-error flag.

module pcap_arb_lane #(
  parameter int CNT_W = 16
) (
  input  logic             clk_out,
  input  logic             rst_n,
  input  logic             valid,
  input  logic             sop,
  input  logic             eop,
  input  logic             is_idle,
  input  logic             is_pkt,
  input  logic             granted,
  input  logic             can_load,
  output logic             ready,
  output logic             req,
  output logic             drain,
  output logic             accept,
  output logic [CNT_W-1:0] pktcount
);
  // A requester always carries sop, so the input picked in IDLE can never also be drained.
  assign req    = valid && sop;
  assign drain  = is_idle && valid && !sop;
  assign ready  = (is_pkt && granted && can_load) || drain;
  assign accept = is_pkt && granted && valid && can_load;

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n)             pktcount <= '0;
    else if (accept && eop) pktcount <= pktcount + 1'b1;
  end
endmodule

module pcap_stream_arbiter_2to1 #(
  parameter int MIN_GAP = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk_out,
  input  logic             rst_n,
  input  logic [63:0]      asi_in0_data,
  input  logic             asi_in0_valid,
  output logic             asi_in0_ready,
  input  logic             asi_in0_sop,
  input  logic             asi_in0_eop,
  input  logic [2:0]       asi_in0_empty,
  input  logic [5:0]       asi_in0_error,
  input  logic [63:0]      asi_in1_data,
  input  logic             asi_in1_valid,
  output logic             asi_in1_ready,
  input  logic             asi_in1_sop,
  input  logic             asi_in1_eop,
  input  logic [2:0]       asi_in1_empty,
  input  logic [5:0]       asi_in1_error,
  output logic [63:0]      aso_out_data,
  output logic             aso_out_valid,
  input  logic             aso_out_ready,
  output logic             aso_out_sop,
  output logic             aso_out_eop,
  output logic [2:0]       aso_out_empty,
  output logic [5:0]       aso_out_error,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] pktcount0,
  output logic [CNT_W-1:0] pktcount1,
  output logic             proto_err
);
  localparam int NUM_IN = 2;
  localparam int GAP_W  = $clog2(MIN_GAP + 2);

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic [5:0]  error;
  } beat_t;

  typedef enum logic [1:0] {S_IDLE, S_PKT, S_GAP} state_t;

  state_t                          state, state_nxt;
  beat_t  [NUM_IN-1:0]             in_beat;
  beat_t                           cur, out_q;
  logic   [NUM_IN-1:0]             in_valid, in_ready, req, drain, accept;
  logic   [NUM_IN-1:0][CNT_W-1:0]  cnt;
  logic   [NUM_IN-1:0]             grant_q;
  logic                            last, first_q, out_valid_q, err_q;
  logic   [GAP_W-1:0]              gap_cnt;
  logic                            is_idle, is_pkt, can_load, gidx, sel_valid, sel_idx, load;

  assign in_beat[0] = {asi_in0_data, asi_in0_sop, asi_in0_eop, asi_in0_empty, asi_in0_error};
  assign in_beat[1] = {asi_in1_data, asi_in1_sop, asi_in1_eop, asi_in1_empty, asi_in1_error};
  assign in_valid   = {asi_in1_valid, asi_in0_valid};

  assign is_idle   = (state == S_IDLE);
  assign is_pkt    = (state == S_PKT);
  assign can_load  = !out_valid_q || aso_out_ready;
  assign gidx      = grant_q[1];
  assign cur       = in_beat[gidx];
  assign load      = |accept;
  assign sel_valid = |req;
  // On a tie the input that did not finish the previous packet wins.
  assign sel_idx   = (&req) ? ~last : req[1];

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    pcap_arb_lane #(.CNT_W(CNT_W)) u_lane (
      .clk_out  (clk_out),
      .rst_n    (rst_n),
      .valid    (in_valid[i]),
      .sop      (in_beat[i].sop),
      .eop      (in_beat[i].eop),
      .is_idle  (is_idle),
      .is_pkt   (is_pkt),
      .granted  (grant_q[i]),
      .can_load (can_load),
      .ready    (in_ready[i]),
      .req      (req[i]),
      .drain    (drain[i]),
      .accept   (accept[i]),
      .pktcount (cnt[i])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (sel_valid) state_nxt = S_PKT;
      S_PKT:   if (load && cur.eop) state_nxt = (MIN_GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (gap_cnt <= GAP_W'(1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      last    <= 1'b1;
      first_q <= 1'b0;
      gap_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (|drain) err_q <= 1'b1;
      case (state)
        S_IDLE: if (sel_valid) begin
          grant_q <= sel_idx ? 2'b10 : 2'b01;
          first_q <= 1'b1;
        end
        S_PKT: if (load) begin
          first_q <= 1'b0;
          // A stray sop inside a packet is flagged but still forwarded.
          if (cur.sop && !first_q) err_q <= 1'b1;
          if (cur.eop) begin
            last    <= gidx;
            grant_q <= '0;
            gap_cnt <= GAP_W'(MIN_GAP);
          end
        end
        S_GAP:   gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (load) begin
      out_q       <= cur;
      out_valid_q <= 1'b1;
    end else if (aso_out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign asi_in0_ready = in_ready[0];
  assign asi_in1_ready = in_ready[1];
  assign aso_out_data  = out_q.data;
  assign aso_out_valid = out_valid_q;
  assign aso_out_sop   = out_q.sop;
  assign aso_out_eop   = out_q.eop;
  assign aso_out_empty = out_q.empty;
  assign aso_out_error = out_q.error;
  assign grant         = grant_q;
  assign pktcount0     = cnt[0];
  assign pktcount1     = cnt[1];
  assign proto_err     = err_q;
endmodule

// File: tb/tb_pcap_stream_arbiter_2to1.sv
// Scoreboard bench for pcap_stream_arbiter_2to1: drivers feed per-input beat queues,
// expected output beats are queued at issue time and a negedge monitor pops and compares.

module tb_pcap_stream_arbiter_2to1;
  localparam int MIN_GAP = 1;
  localparam int CNT_W   = 16;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic [5:0]  error;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][63:0] in_data  = '0;
  logic [1:0]       in_valid = '0;
  logic [1:0]       in_sop   = '0;
  logic [1:0]       in_eop   = '0;
  logic [1:0][2:0]  in_empty = '0;
  logic [1:0][5:0]  in_error = '0;
  logic [1:0]       in_ready;
  logic [63:0]      aso_out_data;
  logic             aso_out_valid, aso_out_sop, aso_out_eop;
  logic             aso_out_ready = 1'b1;
  logic [2:0]       aso_out_empty;
  logic [5:0]       aso_out_error;
  logic [1:0]       grant;
  logic [CNT_W-1:0] pktcount0, pktcount1;
  logic             proto_err;

  pcap_stream_arbiter_2to1 #(.MIN_GAP(MIN_GAP), .CNT_W(CNT_W)) dut (
    .clk_out(clk), .rst_n(rst_n),
    .asi_in0_data(in_data[0]), .asi_in0_valid(in_valid[0]), .asi_in0_ready(in_ready[0]),
    .asi_in0_sop(in_sop[0]), .asi_in0_eop(in_eop[0]), .asi_in0_empty(in_empty[0]),
    .asi_in0_error(in_error[0]),
    .asi_in1_data(in_data[1]), .asi_in1_valid(in_valid[1]), .asi_in1_ready(in_ready[1]),
    .asi_in1_sop(in_sop[1]), .asi_in1_eop(in_eop[1]), .asi_in1_empty(in_empty[1]),
    .asi_in1_error(in_error[1]),
    .aso_out_data(aso_out_data), .aso_out_valid(aso_out_valid), .aso_out_ready(aso_out_ready),
    .aso_out_sop(aso_out_sop), .aso_out_eop(aso_out_eop), .aso_out_empty(aso_out_empty),
    .aso_out_error(aso_out_error),
    .grant(grant), .pktcount0(pktcount0), .pktcount1(pktcount1), .proto_err(proto_err)
  );

  beat_t src_q[2][$];
  beat_t exp_q[$];
  int    sop_cyc[$];
  int    eop_cyc[$];
  int    pres_cyc[2];
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic beat_t mk(input logic [63:0] d, input logic s, input logic e,
                               input logic [2:0] emp, input logic [5:0] er);
    beat_t b;
    b.data = d; b.sop = s; b.eop = e; b.empty = emp; b.error = er;
    return b;
  endfunction

  // n beats with data base*(k+1); only the first n_exp of them are expected on the output.
  task automatic push_pkt(input int p, input int n, input logic [63:0] base,
                          input logic [2:0] last_empty, input int n_exp);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b = mk(base * 64'(k + 1), k == 0, k == n - 1,
             (k == n - 1) ? last_empty : 3'd0, (k == n - 1) ? 6'h2A : 6'h00);
      src_q[p].push_back(b);
      if (k < n_exp) exp_q.push_back(b);
    end
  endtask

  task automatic src_run(input int p);
    logic took;
    forever begin
      @(negedge clk);
      took = in_valid[p] && in_ready[p];
      @(posedge clk); #1;
      if (took && src_q[p].size() > 0) void'(src_q[p].pop_front());
      if (src_q[p].size() > 0) begin
        if (!in_valid[p] && src_q[p][0].sop) pres_cyc[p] = cyc;
        in_data[p]  = src_q[p][0].data;
        in_sop[p]   = src_q[p][0].sop;
        in_eop[p]   = src_q[p][0].eop;
        in_empty[p] = src_q[p][0].empty;
        in_error[p] = src_q[p][0].error;
        in_valid[p] = 1'b1;
      end else begin
        in_valid[p] = 1'b0;
      end
    end
  endtask

  // Monitor: scoreboard pops plus hold-stability check under backpressure.
  logic        pv = 1'b0, pr = 1'b0;
  logic [63:0] p_data;
  logic [11:0] p_ctl;
  beat_t       e_b;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
        continue;
      end
      if (pv && !pr) begin
        chk("hold_data", aso_out_data, p_data);
        chk("hold_ctl", 64'({aso_out_valid, aso_out_sop, aso_out_eop, aso_out_empty, aso_out_error}),
            64'(p_ctl));
      end
      if (aso_out_valid && aso_out_ready) begin
        if (aso_out_sop) sop_cyc.push_back(cyc);
        if (aso_out_eop) eop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data=%0h expected no beat (cycle %0d)", aso_out_data, cyc);
        end else begin
          e_b = exp_q.pop_front();
          chk("beat_data", aso_out_data, e_b.data);
          chk("beat_ctl", 64'({aso_out_sop, aso_out_eop, aso_out_empty, aso_out_error}),
              64'({e_b.sop, e_b.eop, e_b.empty, e_b.error}));
        end
      end
      pv = aso_out_valid;
      pr = aso_out_ready;
      p_data = aso_out_data;
      p_ctl = {aso_out_valid, aso_out_sop, aso_out_eop, aso_out_empty, aso_out_error};
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() > 0 || src_q[0].size() > 0 || src_q[1].size() > 0 || aso_out_valid)
           && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    repeat (MIN_GAP + 3) @(negedge clk);
  endtask

  task automatic wait_out(input string name);
    int n = 0;
    @(negedge clk);
    while (!aso_out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(aso_out_valid), 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sop_cyc.delete();
    eop_cyc.delete();
    @(posedge clk); #2;
  endtask

  int  rc, g00;
  bit  ov, saw01, saw10, bad;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      src_run(0);
      src_run(1);
    join_none
    #1;
    chk("rst_out_valid", 64'(aso_out_valid), 64'd0);
    chk("rst_out_data", aso_out_data, 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_counts", 64'({pktcount1, pktcount0}), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    chk("rst_readies", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single 3-beat packet on in0
    @(posedge clk); #2;
    push_pkt(0, 3, 64'h1111_1111_1111_1111, 3'd5, 3);
    wait_drain("t1_drain");
    chk("t1_latency", 64'((sop_cyc.size() > 0) ? sop_cyc[0] - pres_cyc[0] : -1), 64'd2);
    chk("t1_pktcount0", 64'(pktcount0), 64'd1);

    // both inputs back-to-back: round-robin order and gap
    do_reset();
    push_pkt(0, 2, 64'h0A0A_0000_0000_0001, 3'd1, 2);
    push_pkt(1, 2, 64'h0B0B_0000_0000_0001, 3'd2, 2);
    push_pkt(0, 2, 64'h0C0C_0000_0000_0001, 3'd3, 2);
    push_pkt(1, 2, 64'h0D0D_0000_0000_0001, 3'd4, 2);
    wait_drain("t2_drain");
    if (sop_cyc.size() >= 4 && eop_cyc.size() >= 4) begin
      for (int i = 0; i < 3; i++)
        chk("t2_idle_gap", 64'(sop_cyc[i+1] - eop_cyc[i] - 1), 64'(MIN_GAP + 1));
    end else begin
      chk("t2_packet_marks", 64'(sop_cyc.size() + eop_cyc.size()), 64'd8);
    end
    chk("t2_pktcount0", 64'(pktcount0), 64'd2);
    chk("t2_pktcount1", 64'(pktcount1), 64'd2);

    // downstream stall for 3 cycles mid-packet
    do_reset();
    push_pkt(0, 4, 64'h3030_0000_0000_0001, 3'd6, 4);
    wait_out("t3_first_out");
    @(posedge clk); #1;
    aso_out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t3_in0_ready_stall", 64'(in_ready[0]), 64'd0);
    end
    @(posedge clk); #1;
    aso_out_ready = 1'b1;
    wait_drain("t3_drain");
    chk("t3_pktcount0", 64'(pktcount0), 64'd1);

    // in1 waits while in0 owns the bus
    do_reset();
    push_pkt(0, 3, 64'h4040_0000_0000_0001, 3'd2, 3);
    repeat (2) begin @(posedge clk); #2; end
    push_pkt(1, 2, 64'h5050_0000_0000_0001, 3'd1, 2);
    saw01 = 0; saw10 = 0; bad = 0; g00 = 0;
    for (int i = 0; i < 40 && !saw10; i++) begin
      @(negedge clk);
      if (grant == 2'b10) saw10 = 1;
      else begin
        if (in_ready[1]) bad = 1;
        if (grant == 2'b01) saw01 = 1;
        else if (saw01) g00++;
      end
    end
    chk("t4_saw_grant01", 64'(saw01), 64'd1);
    chk("t4_in1_stalled", 64'(bad), 64'd0);
    chk("t4_grant10", 64'(saw10), 64'd1);
    chk("t4_grant00_cycles", 64'(g00), 64'(MIN_GAP + 1));
    wait_drain("t4_drain");
    chk("t4_pktcount1", 64'(pktcount1), 64'd1);

    // beat without sop in IDLE is drained and flagged
    do_reset();
    src_q[0].push_back(mk(64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, 3'd0, 6'h00));
    rc = 0; ov = 0;
    repeat (5) begin
      @(negedge clk);
      rc += int'(in_ready[0]);
      if (aso_out_valid) ov = 1;
    end
    chk("t5_drain_ready_cycles", 64'(rc), 64'd1);
    chk("t5_no_output", 64'(ov), 64'd0);
    chk("t5_proto_err", 64'(proto_err), 64'd1);
    @(posedge clk); #2;
    push_pkt(0, 1, 64'h6060_0000_0000_0001, 3'd7, 1);
    wait_drain("t5_drain");
    chk("t5_proto_err_sticky", 64'(proto_err), 64'd1);
    chk("t5_pktcount0", 64'(pktcount0), 64'd1);

    // async reset on beat 2 of a 4-beat packet
    @(posedge clk); #2;
    push_pkt(0, 4, 64'h7070_0000_0000_0001, 3'd0, 1);
    wait_out("t6_first_out");
    @(posedge clk); #2;
    rst_n = 1'b0;
    src_q[0].delete();
    #1;
    chk("t6_rst_out_valid", 64'(aso_out_valid), 64'd0);
    chk("t6_rst_grant", 64'(grant), 64'd0);
    chk("t6_rst_pktcount0", 64'(pktcount0), 64'd0);
    chk("t6_rst_proto_err", 64'(proto_err), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
    push_pkt(1, 3, 64'h8080_0000_0000_0001, 3'd4, 3);
    wait_drain("t6_drain");
    chk("t6_pktcount1", 64'(pktcount1), 64'd1);
    chk("t6_pktcount0", 64'(pktcount0), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
